// File: rtl/systolic_feeder_if.sv
// Bus between a host and the systolic feeder: operand buffer writes, run control,
// and the skewed left/top edge streams that go into the PE array.
interface systolic_feeder_if #(
    parameter int DW = 8,
    parameter int N  = 4
);
    logic                 wr_en;
    logic                 wr_b;
    logic [$clog2(N)-1:0] wr_row;
    logic [$clog2(N)-1:0] wr_col;
    logic [DW-1:0]        wr_data;
    logic                 start;
    logic                 abort;
    logic                 clr;
    logic [N*DW-1:0]      x_o;
    logic [N*DW-1:0]      y_o;
    logic                 busy;
    logic                 done;

    modport master (
        output wr_en, wr_b, wr_row, wr_col, wr_data, start, abort,
        input  clr, x_o, y_o, busy, done
    );

    modport slave (
        input  wr_en, wr_b, wr_row, wr_col, wr_data, start, abort,
        output clr, x_o, y_o, busy, done
    );
endinterface

// File: rtl/systolic_feeder.sv
// Buffers operand matrices A and B and streams them, skewed and zero-padded, into the
// left (x) and top (y) edges of an NxN systolic PE array, with clr before and done after.
module systolic_feeder #(
    parameter int DW = 8,
    parameter int N  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    systolic_feeder_if.slave bus
);
    localparam int AW = $clog2(N);
    localparam int TW = $clog2(3 * N);
    localparam logic [TW-1:0] T_LAST = TW'(3 * N - 3);

    typedef enum logic [1:0] {S_IDLE, S_CLR, S_FEED, S_DONE} state_t;

    state_t          state_reg;
    logic [TW-1:0]   t_reg;
    logic            clr_reg;
    logic            busy_reg;
    logic            done_reg;
    logic [N*DW-1:0] x_reg;
    logic [N*DW-1:0] y_reg;
    logic [N*DW-1:0] x_next;
    logic [N*DW-1:0] y_next;
    logic [TW-1:0]   t_next;

    logic [DW-1:0] a_mem [N][N];
    logic [DW-1:0] b_mem [N][N];

    // Operand buffers are frozen for the whole run so the streams stay consistent.
    always_ff @(posedge clk) begin
        if (bus.wr_en && !busy_reg) begin
            if (bus.wr_b) begin
                b_mem[bus.wr_row][bus.wr_col] <= bus.wr_data;
            end else begin
                a_mem[bus.wr_row][bus.wr_col] <= bus.wr_data;
            end
        end
    end

    // Feed step that the registered lanes will present during the next cycle.
    assign t_next = (state_reg == S_FEED) ? t_reg + 1'b1 : '0;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_lane
            logic [TW-1:0] k;
            logic          in_win;

            // Lane gi is delayed by gi cycles; k is the operand index inside the row/column.
            assign k      = t_next - TW'(gi);
            assign in_win = (t_next >= TW'(gi)) && (k < TW'(N));
            assign x_next[gi*DW +: DW] = in_win ? a_mem[gi][k[AW-1:0]] : '0;
            assign y_next[gi*DW +: DW] = in_win ? b_mem[k[AW-1:0]][gi] : '0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            t_reg     <= '0;
            clr_reg   <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            x_reg     <= '0;
            y_reg     <= '0;
        end else begin
            clr_reg  <= 1'b0;
            done_reg <= 1'b0;
            x_reg    <= '0;
            y_reg    <= '0;
            case (state_reg)
                S_IDLE: begin
                    if (bus.start && !bus.abort) begin
                        state_reg <= S_CLR;
                        clr_reg   <= 1'b1;
                        busy_reg  <= 1'b1;
                    end
                end
                S_CLR: begin
                    if (bus.abort) begin
                        state_reg <= S_IDLE;
                        busy_reg  <= 1'b0;
                    end else begin
                        state_reg <= S_FEED;
                        t_reg     <= '0;
                        x_reg     <= x_next;
                        y_reg     <= y_next;
                    end
                end
                S_FEED: begin
                    if (bus.abort) begin
                        state_reg <= S_IDLE;
                        t_reg     <= '0;
                        busy_reg  <= 1'b0;
                    end else if (t_reg == T_LAST) begin
                        state_reg <= S_DONE;
                        t_reg     <= '0;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end else begin
                        t_reg <= t_next;
                        x_reg <= x_next;
                        y_reg <= y_next;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.clr  = clr_reg;
    assign bus.busy = busy_reg;
    assign bus.done = done_reg;
    assign bus.x_o  = x_reg;
    assign bus.y_o  = y_reg;
endmodule
